debounce_sync: RTL
==================

Name: debounce_sync

Overview:
- Conditions a raw asynchronous single-bit input (push-button or switch) into a clean, clock-synchronous level.
- Emits single-cycle rise/fall pulses.
- Sits directly upstream of the flip-flop/register stage: clean_out drives that stage's din.
- Consists of a synchronizer chain, then a stability counter and FSM.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; must be >= 2.
- STABLE_COUNT, 50000, consecutive differing synchronized samples required to accept a new level; 2 <= STABLE_COUNT < 2**CNT_WIDTH.
- CNT_WIDTH, 16, stability counter width.

Ports:
- clk  input  1  single system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- btn_in  input  1  raw asynchronous input.
- enable  input  1  1 = debounce active; 0 = hold clean_out, abort any pending change.
- clean_out  output  1  debounced level.
- rise_pulse  output  1  one-cycle pulse when clean_out goes 0->1.
- fall_pulse  output  1  one-cycle pulse when clean_out goes 1->0.
- busy  output  1  high while a candidate change is being qualified.

Behaviour:
- Reset (reset=0, asynchronous, immediate):
  - sync chain all 0, counter 0, state IDLE_LOW.
  - clean_out=0, rise_pulse=0, fall_pulse=0, busy=0.
- Synchronizer: btn_in passes through SYNC_STAGES flops; s = last stage. It runs regardless of enable.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. clean_out=1 in IDLE_HIGH and WAIT_LOW.
- IDLE_LOW: s=1 and enable=1 -> WAIT_HIGH, count=1.
- WAIT_HIGH:
  - s=0 -> IDLE_LOW, count=0, no pulse (glitch rejected).
  - s=1 and count==STABLE_COUNT-1 -> IDLE_HIGH, count=0, clean_out=1, rise_pulse=1 for that cycle only.
  - otherwise count+1.
- IDLE_HIGH / WAIT_LOW: mirror images of the above, with s=0 as the candidate; completion sets clean_out=0 and fall_pulse=1.
- busy=1 exactly in the WAIT_* states.
- Latency: counting from the first posedge that samples btn_in at the new value (held stable), clean_out and the pulse update on posedge number SYNC_STAGES+STABLE_COUNT.
- All outputs are registered; pulses never exceed one cycle; rise_pulse and fall_pulse are never both high.
- enable=0 in any state:
  - next state is the IDLE_* matching the current clean_out, count=0, no pulses.
  - clean_out holds.
  - After enable returns to 1, a full STABLE_COUNT qualification restarts.
- Counter never wraps: by construction it is bounded by STABLE_COUNT-1.
- Reset mid-qualification: immediate clear to reset values. A btn_in=1 held through reset release qualifies normally and produces rise_pulse.

Decomposition:
- Package debounce_pkg holds:
  - state enum typedef (IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW, 2-bit encoding);
  - default parameter constants.
- One sub-module, sync_chain:
  - parameterized by SYNC_STAGES;
  - ports clk, reset, d, q;
  - async active-low reset to 0.
- The FSM and counter live in debounce_sync.

Test Plan (SYNC_STAGES=2, STABLE_COUNT=4, CNT_WIDTH=4):
1. Drive reset=0 with btn_in=1 -> all outputs 0 immediately. Release reset, hold btn_in=1 -> clean_out=1 after 6th posedge, rise_pulse high exactly that one cycle, busy high after posedges 3-5.
2. From IDLE_HIGH, drive btn_in=0 held 10 cycles -> clean_out=0 after 6th posedge, fall_pulse one cycle, rise_pulse stays 0.
3. From IDLE_LOW, bounce btn_in 1,1,1,0,1,0,0 (one value per cycle) -> clean_out stays 0, no pulses, busy returns to 0, count returns to 0.
4. From IDLE_LOW, btn_in=1 and drop enable=0 after posedge 4 for 3 cycles, then enable=1 -> no change while disabled; clean_out=1 exactly 4 posedges after enable returns.
5. From WAIT_HIGH with count=2, assert reset=0 between edges -> outputs 0 and state IDLE_LOW without waiting for a clock edge.
6. Toggle btn_in every 3 cycles for 100 cycles -> clean_out constant, zero pulses. Then hold btn_in stable -> exactly one pulse per accepted change.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and default parameter values for the push-button debouncer.
//   state_e           : FSM state encoding (2 bits)
//   DefSyncStages     : default synchronizer depth
//   DefStableCount    : default number of stable samples needed to accept a level
//   DefCntWidth       : default stability counter width
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } state_e;

   localparam int unsigned DefSyncStages  = 2;
   localparam int unsigned DefStableCount = 50000;
   localparam int unsigned DefCntWidth    = 16;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous bit into the clk domain.
// Ports:
//   clk   : sampling clock
//   reset : asynchronous active-low reset, clears every stage to 0
//   d     : asynchronous input
//   q     : synchronized output (last stage)
module sync_chain
   import debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DefSyncStages
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Debouncer: synchronizes a raw button/switch input, then accepts a new level only after
// STABLE_COUNT consecutive synchronized samples at that level. Emits one-cycle edge pulses.
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   btn_in     : raw asynchronous input
//   enable     : 1 = debounce active, 0 = hold clean_out and abort any pending change
//   clean_out  : debounced level (registered)
//   rise_pulse : one-cycle pulse on clean_out 0->1
//   fall_pulse : one-cycle pulse on clean_out 1->0
//   busy       : high while a candidate change is being qualified
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = DefSyncStages,
   parameter int unsigned STABLE_COUNT = DefStableCount,
   parameter int unsigned CNT_WIDTH    = DefCntWidth
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   input  logic enable,
   output logic clean_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
);

   localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(STABLE_COUNT - 1);

   logic s;

   sync_chain #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_chain (
      .clk  (clk),
      .reset(reset),
      .d    (btn_in),
      .q    (s)
   );

   state_e                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;

      if (!enable) begin
         // Park in the idle state that matches the level currently presented.
         state_d = (state_q == IDLE_HIGH || state_q == WAIT_LOW) ? IDLE_HIGH : IDLE_LOW;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE_LOW: begin
               if (s) begin
                  state_d = WAIT_HIGH;
                  cnt_d   = CntOne;
               end
            end
            WAIT_HIGH: begin
               if (!s) begin
                  state_d = IDLE_LOW;
                  cnt_d   = '0;
               end else if (cnt_q == LastCnt) begin
                  state_d = IDLE_HIGH;
                  cnt_d   = '0;
                  rise_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
            IDLE_HIGH: begin
               if (!s) begin
                  state_d = WAIT_LOW;
                  cnt_d   = CntOne;
               end
            end
            WAIT_LOW: begin
               if (s) begin
                  state_d = IDLE_HIGH;
                  cnt_d   = '0;
               end else if (cnt_q == LastCnt) begin
                  state_d = IDLE_LOW;
                  cnt_d   = '0;
                  fall_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
            default: begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end
         endcase
      end

      // Level and busy are decoded from the next state so they land in the same edge.
      clean_d = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
      busy_d  = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
         clean_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   assign clean_out  = clean_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign busy       = busy_q;

endmodule
